// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: sequences the shared datapath over 3-5 cycles
// per instruction, holds NZCV and predicates all architectural writes.
module multicycle_control_fsm #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemW,
    output logic       RegW,
    output logic [1:0] ResultSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] flags_q;
    logic [3:0] cmd;
    logic       n, z, c, v;
    logic       cond_ex;
    logic       no_write;
    logic       arith;
    logic       flag_upd;
    logic [2:0] alu_dec;

    assign cmd          = Funct[4:1];
    assign {n, z, c, v} = flags_q;
    assign State        = state_q;

    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Unsupported data-processing commands execute as a harmless ADD
    // with no register write.
    always_comb begin
        alu_dec  = 3'b000;
        no_write = 1'b1;
        case (cmd)
            4'b0100: begin alu_dec = 3'b000; no_write = 1'b0; end
            4'b0010: begin alu_dec = 3'b001; no_write = 1'b0; end
            4'b0000: begin alu_dec = 3'b010; no_write = 1'b0; end
            4'b1100: begin alu_dec = 3'b011; no_write = 1'b0; end
            4'b1010: begin alu_dec = 3'b001; no_write = 1'b1; end
            default: begin alu_dec = 3'b000; no_write = 1'b1; end
        endcase
    end

    assign arith    = (cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010);
    assign flag_upd = ((state_q == EXECR) | (state_q == EXECI))
                    & Funct[0] & cond_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= RESET_FLAGS;
        end else if (flag_upd) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (arith) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = FETCH;
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        MemW       = 1'b0;
        RegW       = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = 3'b000;
        case (state_q)
            FETCH: begin
                state_d   = DECODE;
                IRWrite   = 1'b1;
                PCWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (Op)
                    2'b01:   state_d = MEMADR;
                    2'b00:   state_d = Funct[5] ? EXECI : EXECR;
                    2'b10:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
                if (Op == 2'b10) begin
                    RegSrc = 2'b01;
                end else if (Op == 2'b01 && !Funct[0]) begin
                    RegSrc = 2'b10;
                end
            end
            MEMADR: begin
                state_d    = Funct[0] ? MEMRD : MEMWR;
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = Funct[3] ? 3'b000 : 3'b001;
            end
            MEMRD: begin
                state_d = MEMWB;
                AdrSrc  = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = cond_ex;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = cond_ex;
                RegSrc = 2'b10;
            end
            EXECR: begin
                state_d    = ALUWB;
                ALUControl = alu_dec;
            end
            EXECI: begin
                state_d    = ALUWB;
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            ALUWB: begin
                RegW    = cond_ex & ~no_write;
                PCWrite = cond_ex & (Rd == 4'hF) & ~no_write;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ResultSrc = 2'b10;
                RegSrc    = 2'b01;
                PCWrite   = cond_ex;
            end
            default: state_d = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios plus random
// instructions checked against an instruction-level reference model.
module tb_multicycle_control_fsm;

    localparam logic [3:0] RF = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, AdrSrc, IRWrite, MemW, RegW, ALUSrcA;
    logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [16:0] act;

    int total = 0;
    int bad   = 0;
    logic [3:0] mflags;

    multicycle_control_fsm #(.RESET_FLAGS(RF)) dut (
        .clk(clk), .rst_n(rst_n), .Cond(Cond), .Op(Op), .Funct(Funct),
        .Rd(Rd), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .MemW(MemW), .RegW(RegW),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .State(State)
    );

    always #5 clk = ~clk;

    assign act = {PCWrite, AdrSrc, IRWrite, MemW, RegW, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    function automatic bit cond_holds(input logic [3:0] cond,
                                      input logic [3:0] f);
        bit fn = f[3], fz = f[2], fc = f[1], fv = f[0];
        bit ge = (fn == fv);
        bit r;
        case (cond)
            4'd0:  r = fz;
            4'd1:  r = !fz;
            4'd2:  r = fc;
            4'd3:  r = !fc;
            4'd4:  r = fn;
            4'd5:  r = !fn;
            4'd6:  r = fv;
            4'd7:  r = !fv;
            4'd8:  r = fc && !fz;
            4'd9:  r = !(fc && !fz);
            4'd10: r = ge;
            4'd11: r = !ge;
            4'd12: r = !fz && ge;
            4'd13: r = !(!fz && ge);
            4'd14: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic bit writes_reg(input logic [3:0] cmd);
        return (cmd == 4'd4) || (cmd == 4'd2) || (cmd == 4'd0)
            || (cmd == 4'd12);
    endfunction

    function automatic logic [2:0] alu_op(input logic [3:0] cmd);
        if (cmd == 4'd2 || cmd == 4'd10) return 3'b001;
        if (cmd == 4'd0) return 3'b010;
        if (cmd == 4'd12) return 3'b011;
        return 3'b000;
    endfunction

    // Expected control word for one cycle, straight from the state table.
    function automatic logic [16:0] exp_ctrl(input int st,
        input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
        input bit ce);
        logic pcw = 0, adr = 0, irw = 0, mw = 0, rw = 0, sa = 0;
        logic [1:0] res = 0, sb = 0, imm = 0, rs = 0;
        logic [2:0] alu = 0;
        bit wr = writes_reg(f[4:1]);
        case (st)
            0: begin pcw = 1; irw = 1; sa = 1; sb = 2; res = 2; end
            1: begin
                sa = 1; sb = 2; res = 2;
                if (op == 2) rs = 1;
                else if (op == 1 && !f[0]) rs = 2;
            end
            2: begin sb = 1; imm = 1; alu = f[3] ? 3'd0 : 3'd1; end
            3: adr = 1;
            4: begin res = 1; rw = ce; end
            5: begin adr = 1; mw = ce; rs = 2; end
            6: alu = alu_op(f[4:1]);
            7: begin sb = 1; alu = alu_op(f[4:1]); end
            8: begin rw = ce && wr; pcw = ce && wr && rd == 4'hF; end
            9: begin sb = 1; imm = 2; res = 2; rs = 1; pcw = ce; end
            default: ;
        endcase
        return {pcw, adr, irw, mw, rw, res, sa, sb, imm, rs, alu};
    endfunction

    // Walks one instruction from FETCH; entered on a falling edge.
    task automatic run_instr(input string name, input logic [3:0] cond,
        input logic [1:0] op, input logic [5:0] f, input logic [3:0] rd,
        input logic [3:0] af, input int max_states);
        int path[$];
        int n;
        bit ce;
        logic [16:0] exp;
        path = {0, 1};
        case (op)
            2'd0: begin path.push_back(f[5] ? 7 : 6); path.push_back(8); end
            2'd1: begin
                path.push_back(2);
                if (f[0]) begin path.push_back(3); path.push_back(4); end
                else path.push_back(5);
            end
            2'd2: path.push_back(9);
            default: ;
        endcase
        Cond = cond; Op = op; Funct = f; Rd = rd; ALUFlags = af;
        n = (max_states > 0 && max_states < path.size()) ? max_states
                                                         : path.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            ce  = cond_holds(cond, mflags);
            exp = exp_ctrl(path[i], op, f, rd, ce);
            total++;
            if (State !== 4'(path[i]) || act !== exp) begin
                bad++;
                $display("FAIL %s step%0d: state=%0d ctrl=%h expected state=%0d ctrl=%h",
                         name, i, State, act, path[i], exp);
            end
            if ((path[i] == 6 || path[i] == 7) && f[0] && ce) begin
                mflags[3:2] = af[3:2];
                if (f[4:1] == 4'd4 || f[4:1] == 4'd2 || f[4:1] == 4'd10)
                    mflags[1:0] = af[1:0];
            end
        end
        if (n == path.size()) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0; Cond = 4'hE; Op = 0; Funct = 0; Rd = 0; ALUFlags = 0;
        mflags = RF;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (State !== 4'd0 || act !== exp_ctrl(0, 0, 0, 0, 1)) begin
            bad++;
            $display("FAIL reset: state=%0d ctrl=%h expected state=0 ctrl=%h",
                     State, act, exp_ctrl(0, 0, 0, 0, 1));
        end
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_alu_reg;
        run_instr("add_reg", 4'hE, 2'b00, 6'b000100, 4'd3, 4'b1111, 0);
        run_instr("add_eq_after", 4'h0, 2'b00, 6'b000100, 4'd3, 4'b0, 0);
    endtask

    task automatic test_sub_imm_flags;
        run_instr("subs_imm", 4'hE, 2'b00, 6'b100101, 4'd5, 4'b0100, 0);
        run_instr("add_eq", 4'h0, 2'b00, 6'b000100, 4'd2, 4'b0000, 0);
        run_instr("and_ne", 4'h1, 2'b00, 6'b000000, 4'd2, 4'b0000, 0);
    endtask

    task automatic test_mem;
        run_instr("ldr", 4'hE, 2'b01, 6'b011001, 4'd4, 4'b0, 0);
        run_instr("str", 4'hE, 2'b01, 6'b010000, 4'd4, 4'b0, 0);
        run_instr("ldr_nv", 4'hF, 2'b01, 6'b010001, 4'd4, 4'b0, 0);
    endtask

    task automatic test_branch;
        @(negedge clk);
        rst_n = 0; #1; rst_n = 1; mflags = RF;
        run_instr("b_eq_z0", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0, 0);
        run_instr("subs_z1", 4'hE, 2'b00, 6'b100101, 4'd1, 4'b0110, 0);
        run_instr("b_eq_z1", 4'h0, 2'b10, 6'b000000, 4'd0, 4'b0, 0);
        run_instr("b_hi", 4'h8, 2'b10, 6'b000000, 4'd0, 4'b0, 0);
    endtask

    task automatic test_pc_write;
        run_instr("cmp_r15", 4'hE, 2'b00, 6'b010101, 4'hF, 4'b1001, 0);
        run_instr("add_r15", 4'hE, 2'b00, 6'b000100, 4'hF, 4'b0, 0);
        run_instr("orr_r15_nv", 4'hF, 2'b00, 6'b011000, 4'hF, 4'b0, 0);
    endtask

    task automatic test_reset_mid;
        run_instr("subs_pre", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0100, 0);
        run_instr("str_abort", 4'hE, 2'b01, 6'b010000, 4'd6, 4'b0, 4);
        rst_n = 0;
        #1;
        mflags = RF;
        total++;
        if (MemW !== 1'b0 || State !== 4'd0 ||
            act !== exp_ctrl(0, Op, Funct, Rd, 1)) begin
            bad++;
            $display("FAIL reset_mid: memw=%b state=%0d ctrl=%h expected memw=0 state=0 ctrl=%h",
                     MemW, State, act, exp_ctrl(0, Op, Funct, Rd, 1));
        end
        @(negedge clk);
        rst_n = 1;
        run_instr("add_eq_post", 4'h0, 2'b00, 6'b000100, 4'd2, 4'b0, 0);
        run_instr("ldr_post", 4'hE, 2'b01, 6'b011001, 4'd2, 4'b0, 0);
    endtask

    task automatic test_illegal;
        run_instr("illegal", 4'hE, 2'b11, 6'b111111, 4'hF, 4'b1111, 0);
        run_instr("after_ill", 4'hE, 2'b00, 6'b001000, 4'd7, 4'b0, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 80; i++) begin
            run_instr("rand", 4'($urandom_range(0, 15)),
                      2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      0);
        end
    endtask

    initial begin
        test_reset();
        test_alu_reg();
        test_sub_imm_flags();
        test_mem();
        test_branch();
        test_pc_write();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Multicycle replacement for the single-cycle ControlUnit. It sequences the shared ALU/memory/register-file datapath of the ARM-subset core over 3–5 cycles per instruction.
- Decodes Op/Funct/Rd from the instruction register and holds the NZCV flags.
- Evaluates the condition field and issues per-state datapath enables and selects.
- Sits between the instruction register and the multicycle datapath muxes.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Cond  in  4  instruction[31:28]
- Op  in  2  instruction[27:26]
- Funct  in  6  instruction[25:20]; [5]=I, [4:1]=cmd, [0]=S (or L for memory ops)
- Rd  in  4  instruction[15:12]
- ALUFlags  in  4  NZCV from ALU in the current cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALU result register
- IRWrite  out  1  instruction register enable
- MemW  out  1  data memory write
- RegW  out  1  register file write
- ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALU result
- ALUSrcA  out  1  0=RD1 reg, 1=PC
- ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  00=imm8, 01=imm12, 10=imm24 branch
- RegSrc  out  2  [0]=RA1 is R15 (branch), [1]=RA2 is Rd (store)
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- State  out  4  current state encoding, for debug/bench

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Any other value goes to FETCH next cycle.
- Reset (async, rst_n=0): State=FETCH, Flags=RESET_FLAGS. All outputs take their FETCH values combinationally.
- Transitions:
  - FETCH→DECODE.
  - DECODE: Op=01→MEMADR; Op=00 with Funct[5]=0→EXECR; Op=00 with Funct[5]=1→EXECI; Op=10→BRANCH; Op=11→FETCH (illegal, no side effects).
  - MEMADR: Funct[0]=1→MEMRD, else→MEMWR.
  - MEMRD→MEMWB; EXECR/EXECI→ALUWB.
  - MEMWB, MEMWR, ALUWB, BRANCH→FETCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=000, ResultSrc=10, PCWrite=1.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALUControl=000. RegSrc is driven for the decoded Op: 01 for branch, 10 for store, 00 otherwise.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=000 if Funct[3] (U) else 001, ImmSrc=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=CondEx.
- MEMWR: AdrSrc=1, MemW=CondEx, RegSrc=10.
- EXECR: ALUSrcB=00. EXECI: ALUSrcB=01, ImmSrc=00. Both use ALUSrcA=0.
- ALU decode in EXECR/EXECI, by cmd:
  - 0100→000; 0010→001; 0000→010; 1100→011.
  - 1010 (CMP)→001 with NoWrite=1.
  - Any other cmd→000 with NoWrite=1.
- ALUWB: ResultSrc=00, RegW=CondEx & ~NoWrite, PCWrite=CondEx & (Rd==4'hF) & ~NoWrite.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ImmSrc=10, ALUControl=000, ResultSrc=10, RegSrc=01, PCWrite=CondEx.
- Unlisted outputs are 0 in each state.
- CondEx is combinational from Cond and the registered Flags:
  - EQ/NE, CS/CC, MI/PL, VS/VC, HI/LS, GE/LT, GT/LE per ARM.
  - 1110→1; 1111→0.
- Flag update: at the rising edge leaving EXECR/EXECI, if Funct[0]=1 and CondEx:
  - N,Z are loaded from ALUFlags.
  - C,V are loaded only when cmd is ADD, SUB or CMP.
- Predicated-off instructions still walk all their states, with write enables held at 0.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write survives.

Test Plan:
- Reset then Cond=1110 ADD register (Op=00, Funct=000100, Rd=3) → State 0,1,6,8,0; RegW=1 only in ALUWB; ALUControl=000; Flags unchanged.
- Cond=1110 SUB immediate with S (Funct=100101), ALUFlags=0100 in EXECI → ALUControl=001; Flags=0100 after EXECI; then Cond=0000 ADD writes the register (CondEx=1).
- LDR (Op=01, Funct=011001, Cond=1110) → State 0,1,2,3,4,0 (5 cycles); AdrSrc=1 in MEMRD; ResultSrc=01 and RegW=1 in MEMWB. STR (Funct=010000) → 0,1,2,5,0 with MemW=1 in MEMWR only.
- Branch with Cond=0000 after reset (Z=0) → BRANCH reached with PCWrite=0; after Flags Z=1 the same branch gives PCWrite=1.
- CMP with S, Rd=15 → ALUWB has RegW=0 and PCWrite=0; ADD with Rd=15, Cond=1110 → PCWrite=1 in ALUWB.
- rst_n pulsed low during MEMWR → MemW drops to 0 asynchronously; State=0 and Flags=RESET_FLAGS; next fetch proceeds normally. Op=11 → DECODE→FETCH with no writes.
